// File: rtl/mem_arbiter_if.sv
// Word-memory bus bundle shared by the arbiter's master ports and its memory port.
// On the memory side valid is the slave select, wdata is s_data_i and rdata is s_data_o.
interface mem_arbiter_if #(
  parameter int unsigned AW = 32
) ();
  logic          valid;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic [3:0]    wstrb;
  logic          ready;
  logic [31:0]   rdata;

  modport master (
    output valid, addr, wdata, wstrb,
    input  ready, rdata
  );

  modport slave (
    input  valid, addr, wdata, wstrb,
    output ready, rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter in front of one single-port word memory, with
// timeout abort of accesses the memory never completes.
module mem_arbiter #(
  parameter int unsigned ADDR_W   = 9,
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave  m0,
  mem_arbiter_if.slave  m1,
  mem_arbiter_if.master s,
  output logic         grant,
  output logic         busy,
  output logic         err
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic              grant_q, grant_d;
  logic              sSelect_q, sSelect_d;
  logic [ADDR_W-1:0] sAddr_q, sAddr_d;
  logic [31:0]       sData_q, sData_d;
  logic [3:0]        sWstrb_q, sWstrb_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              m0Ready_q, m0Ready_d;
  logic              m1Ready_q, m1Ready_d;
  logic [31:0]       m0Rdata_q, m0Rdata_d;
  logic [31:0]       m1Rdata_q, m1Rdata_d;
  logic              err_q, err_d;

  logic              winner;
  logic              finish;
  logic              timedOut;
  logic [31:0]       finData;
  logic              cntAtLimit;
  logic              unusedBits;

  assign cntAtLimit = (32'(cnt_q) == (TIMEOUT - 32'd1));

  // Only the word-index slice of the byte addresses reaches the memory.
  assign unusedBits = ^{m0.addr[31:ADDR_W+2], m0.addr[1:0],
                        m1.addr[31:ADDR_W+2], m1.addr[1:0]};

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    sSelect_d = sSelect_q;
    sAddr_d   = sAddr_q;
    sData_d   = sData_q;
    sWstrb_d  = sWstrb_q;
    cnt_d     = cnt_q;
    m0Ready_d = 1'b0;
    m1Ready_d = 1'b0;
    m0Rdata_d = m0Rdata_q;
    m1Rdata_d = m1Rdata_q;
    err_d     = 1'b0;
    winner    = 1'b0;
    finish    = 1'b0;
    timedOut  = 1'b0;
    finData   = '0;

    unique case (state_q)
      IDLE: begin
        if (m0.valid || m1.valid) begin
          // On a tie the master that did not win last time goes first.
          if (m0.valid && m1.valid) begin
            winner = ~grant_q;
          end else begin
            winner = m1.valid;
          end
          grant_d   = winner;
          sAddr_d   = winner ? m1.addr[ADDR_W+1:2] : m0.addr[ADDR_W+1:2];
          sData_d   = winner ? m1.wdata : m0.wdata;
          sWstrb_d  = winner ? m1.wstrb : m0.wstrb;
          sSelect_d = 1'b1;
          cnt_d     = '0;
          state_d   = ACCESS;
        end
      end

      ACCESS: begin
        if (s.ready) begin
          finish  = 1'b1;
          finData = (sWstrb_q == 4'b0000) ? s.rdata : 32'h0;
        end else if ((TIMEOUT != 0) && cntAtLimit) begin
          finish   = 1'b1;
          timedOut = 1'b1;
          finData  = ERR_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end

        if (finish) begin
          if (grant_q) begin
            m1Ready_d = 1'b1;
            m1Rdata_d = finData;
          end else begin
            m0Ready_d = 1'b1;
            m0Rdata_d = finData;
          end
          sSelect_d = 1'b0;
          sWstrb_d  = 4'b0000;
          err_d     = timedOut;
          state_d   = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= 1'b1;
      sSelect_q <= 1'b0;
      sAddr_q   <= '0;
      sData_q   <= '0;
      sWstrb_q  <= '0;
      cnt_q     <= '0;
      m0Ready_q <= 1'b0;
      m1Ready_q <= 1'b0;
      m0Rdata_q <= '0;
      m1Rdata_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      sSelect_q <= sSelect_d;
      sAddr_q   <= sAddr_d;
      sData_q   <= sData_d;
      sWstrb_q  <= sWstrb_d;
      cnt_q     <= cnt_d;
      m0Ready_q <= m0Ready_d;
      m1Ready_q <= m1Ready_d;
      m0Rdata_q <= m0Rdata_d;
      m1Rdata_q <= m1Rdata_d;
      err_q     <= err_d;
    end
  end

  assign s.valid  = sSelect_q;
  assign s.addr   = sAddr_q;
  assign s.wdata  = sData_q;
  assign s.wstrb  = sWstrb_q;
  assign m0.ready = m0Ready_q;
  assign m0.rdata = m0Rdata_q;
  assign m1.ready = m1Ready_q;
  assign m1.rdata = m1Rdata_q;
  assign grant    = grant_q;
  assign busy     = (state_q != IDLE);
  assign err      = err_q;

endmodule
